// File: rtl/id_range_scanner_if.sv
// id_range_scanner_if: request/result handshake bundle for id_range_scanner (out_count under ID_RANGE_SCANNER_COUNT_EN)
interface id_range_scanner_if #(
    parameter int W = 48
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_start;
    logic [W-1:0] in_end;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_mode;
    logic         busy;
`ifdef ID_RANGE_SCANNER_COUNT_EN
    logic [W-1:0] out_count;
`endif
    modport master (
        output in_valid, in_start, in_end, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_mode, busy
`ifdef ID_RANGE_SCANNER_COUNT_EN
        , input out_count
`endif
    );
    modport slave (
        input  in_valid, in_start, in_end, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_mode, busy
`ifdef ID_RANGE_SCANNER_COUNT_EN
        , output out_count
`endif
    );
endinterface

// File: rtl/id_range_scanner.sv
// id_range_scanner: sums repeated-digit IDs over queued ranges; ID_RANGE_SCANNER_COUNT_EN adds out_count
module id_range_scanner #(
    parameter int W     = 48,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    id_range_scanner_if.slave bus
);
    localparam int ND = W * 30103 / 100000 + 1;
    localparam int NW = $clog2(ND + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = 4 * ND;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

    function automatic logic [BW-1:0] to_bcd(input logic [W-1:0] v);
        logic [BW-1:0] b;
        b = '0;
        for (int i = W - 1; i >= 0; i--) begin
            for (int j = 0; j < ND; j++)
                if (b[4*j+:4] >= 4'd5) b[4*j+:4] = b[4*j+:4] + 4'd3;
            b = {b[BW-2:0], v[i]};
        end
        return b;
    endfunction

    function automatic logic [NW-1:0] ndigits(input logic [BW-1:0] b);
        logic [NW-1:0] n;
        n = NW'(1);
        for (int j = 1; j < ND; j++)
            if (b[4*j+:4] != 4'd0) n = NW'(j + 1);
        return n;
    endfunction

    // a digit string is a repetition of its first l digits iff it has period l and l divides its length
    function automatic logic repeats(input logic [BW-1:0] b, input int n, input logic m);
        logic r, ok;
        r = 1'b0;
        for (int l = 1; l < ND; l++) begin
            ok = l < n && n % l == 0 && (m || 2 * l == n);
            for (int i = 0; i < ND - l; i++)
                if (i + l < n && b[4*i+:4] != b[4*(i+l)+:4]) ok = 1'b0;
            r = r | ok;
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          dcnt_q, dcnt_d;
    logic [W-1:0]        cur_q, cur_d, end_q, end_d, acc_q, acc_d, lsum;
    logic                mode_q, mode_d;
    logic [2*W:0]        mem_q [DEPTH];
    logic [AW:0]         wp_q, rp_q;
    logic                empty, full, push, pop, last;
    logic [W:0]          lx     [LANES];
    logic [LANES-1:0]    lv, v1_q, v2_q, bad_q, hit_q;
    logic [W-1:0]        id1_q  [LANES];
    logic [W-1:0]        id2_q  [LANES];
    logic [W-1:0]        id3_q  [LANES];
    logic [W-1:0]        val_q  [LANES];
    logic [BW-1:0]       bcd1_q [LANES];
    logic [BW-1:0]       bcd2_q [LANES];
    logic [NW-1:0]       nd2_q  [LANES];
`ifdef ID_RANGE_SCANNER_COUNT_EN
    logic [W-1:0]        cnt_q, cnt_d, lcnt;
`endif

    assign empty        = wp_q == rp_q;
    assign full         = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
    assign push         = bus.in_valid && !full;
    assign pop          = state_q == IDLE && !empty;
    assign bus.in_ready = !full;

    // FIFO pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + (AW+1)'(1);
            if (pop) rp_q <= rp_q + (AW+1)'(1);
        end
    end

    // FIFO storage, entry = {mode, end, start}
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q[AW-1:0]] <= {bus.in_mode, bus.in_end, bus.in_start};
    end

    // candidate IDs for this cycle, compared in W+1 bits so the range end never wraps
    always_comb begin
        lv   = '0;
        last = {1'b0, cur_q} + (W+1)'(LANES - 1) >= {1'b0, end_q};
        for (int k = 0; k < LANES; k++) begin
            lx[k] = {1'b0, cur_q} + (W+1)'(k);
            lv[k] = state_q == SCAN && lx[k] <= {1'b0, end_q};
        end
    end

    // state and range registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            cur_q   <= '0;
            end_q   <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
`ifdef ID_RANGE_SCANNER_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
`ifdef ID_RANGE_SCANNER_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // next state: DRAIN waits out the lane pipeline and the accumulator stage
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        cur_d   = cur_q;
        end_d   = end_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: if (pop) begin
                state_d = SCAN;
                {mode_d, end_d, cur_d} = mem_q[rp_q[AW-1:0]];
            end
            SCAN: begin
                cur_d  = cur_q + W'(LANES);
                dcnt_d = '0;
                if (last) state_d = DRAIN;
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 3'd1;
                if (dcnt_q == 3'd4) state_d = RESULT;
            end
            default: if (bus.out_ready) state_d = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        bus.out_valid = state_q == RESULT;
        bus.busy      = state_q != IDLE || !empty;
        bus.out_sum   = acc_q;
        bus.out_mode  = mode_q;
`ifdef ID_RANGE_SCANNER_COUNT_EN
        bus.out_count = cnt_q;
`endif
    end

    // lane data path: BCD, digit count, carried IDs
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANES; k++) begin
            bcd1_q[k] <= to_bcd(lx[k][W-1:0]);
            id1_q[k]  <= lx[k][W-1:0];
            bcd2_q[k] <= bcd1_q[k];
            nd2_q[k]  <= ndigits(bcd1_q[k]);
            id2_q[k]  <= id1_q[k];
            id3_q[k]  <= id2_q[k];
        end
    end

    // lane control path: validity, repetition flag, masked lane value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q  <= '0;
            v2_q  <= '0;
            bad_q <= '0;
            hit_q <= '0;
            for (int k = 0; k < LANES; k++) val_q[k] <= '0;
        end else begin
            v1_q  <= lv;
            v2_q  <= v1_q;
            hit_q <= bad_q;
            for (int k = 0; k < LANES; k++) begin
                bad_q[k] <= v2_q[k] && repeats(bcd2_q[k], int'(nd2_q[k]), mode_q);
                val_q[k] <= bad_q[k] ? id3_q[k] : '0;
            end
        end
    end

    // accumulator: add this cycle's lane values, clear when a new range is popped
    always_comb begin
        lsum = '0;
        for (int k = 0; k < LANES; k++) lsum = lsum + val_q[k];
        acc_d = pop ? '0 : acc_q + lsum;
`ifdef ID_RANGE_SCANNER_COUNT_EN
        lcnt = '0;
        for (int k = 0; k < LANES; k++) lcnt = lcnt + W'(hit_q[k]);
        cnt_d = pop ? '0 : cnt_q + lcnt;
`endif
    end
endmodule
